// File: rtl/serial_frame_deserializer_pkg.sv
// Shared types and line-level constants for the serial frame deserializer.
// Defining SERIAL_FRAME_PARITY_EN enables the PARITY state in the top level.
package serial_frame_deserializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic IDLE_LEVEL = 1'b0;
  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;

endpackage

// File: rtl/serial_frame_deserializer_if.sv
// Parallel valid/ready output bus of the deserializer.
// The master side drives the word; the slave side consumes it.
interface serial_frame_deserializer_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output data_out,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  data_out,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/serial_frame_deserializer_shift_core.sv
// Data shift register and bit counter; bits enter at the MSB end so the
// first received bit ends up at bit 0 after DATA_W shifts.
module sfd_shift_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en_i,
  input  logic              clear_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (shift_en_i) begin
      sreg_d = {bit_i, sreg_q[DATA_W-1:1]};
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o  = sreg_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/serial_frame_deserializer.sv
// Serial frame deserializer: start bit, DATA_W data bits LSB-first, optional
// even parity (SERIAL_FRAME_PARITY_EN), stop bit; valid/ready word output.
module serial_frame_deserializer
  import serial_frame_deserializer_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         serial_in,
  serial_frame_deserializer_if.master  bus,
  output logic                         frame_err,
  output logic                         parity_err,
  output logic                         overrun,
  output logic                         busy
);

  state_e            state_q, state_d;
  logic              shift_en, cnt_clear, in_stop;
  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  cnt;
  logic              last_bit, stop_ok, par_ok, good;

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  sfd_shift_core #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .shift_en_i (shift_en),
    .clear_i    (cnt_clear),
    .bit_i      (serial_in),
    .data_o     (sreg),
    .count_o    (cnt)
  );

  assign last_bit = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (serial_in == START_BIT) state_d = DATA;
      DATA: begin
        if (last_bit) begin
`ifdef SERIAL_FRAME_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef SERIAL_FRAME_PARITY_EN
      PARITY:  state_d = STOP;
`endif
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_en  = (state_q == DATA);
    cnt_clear = (state_q == IDLE);
    in_stop   = (state_q == STOP);
    busy      = (state_q != IDLE);
  end

  assign stop_ok = (serial_in == STOP_BIT);

`ifdef SERIAL_FRAME_PARITY_EN
  logic par_q, perr_q, perr_d;

  always_ff @(posedge clk) begin
    if (reset)                  par_q <= 1'b0;
    else if (state_q == PARITY) par_q <= serial_in;
  end

  assign par_ok     = ~(^{sreg, par_q});
  assign parity_err = perr_q;
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign good = in_stop & stop_ok & par_ok;

  // A good frame landing on a consume edge reloads the word instead of clearing.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = in_stop & ~(stop_ok & par_ok);
`ifdef SERIAL_FRAME_PARITY_EN
    perr_d  = in_stop & ~par_ok;
`endif
    if (valid_q && bus.out_ready) valid_d = 1'b0;
    if (good) begin
      if (valid_q && !bus.out_ready) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = sreg;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef SERIAL_FRAME_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.data_out  = data_q;
  assign bus.out_valid = valid_q;
  assign frame_err     = ferr_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Scoreboard bench for serial_frame_deserializer at DATA_W=8; parity cases
// are exercised when SERIAL_FRAME_PARITY_EN is defined.
module tb_serial_frame_deserializer;

`ifdef SERIAL_FRAME_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, serial_in;
  logic frame_err, parity_err, overrun, busy;

  serial_frame_deserializer_if #(.DATA_W(8)) bus ();

  serial_frame_deserializer #(.DATA_W(8), .CNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .bus        (bus),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp;
    if (exp_q.size() == 0) begin
      errs++;
      $display("FAIL scoreboard_underflow: got empty queue want an entry");
      exp = 8'hxx;
    end else begin
      exp = exp_q.pop_front();
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    serial_in = 1'b0;
    tick;
    reset = 1'b0;
  endtask

  // Returns #1 after the stop edge with serial_in back at idle.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic par_flip, input bit rdy_chg,
                            input logic rdy_v);
    serial_in = 1'b1;
    tick;
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      tick;
    end
    if (PAR_EN) begin
      serial_in = (^d) ^ par_flip;
      tick;
    end
    if (rdy_chg) bus.out_ready = rdy_v;
    serial_in = stop_b;
    tick;
    serial_in = 1'b0;
  endtask

  task automatic test_reset;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    serial_in = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    serial_in = 1'b0;
    vecs++; if (bus.data_out !== 8'h00) begin errs++; $display("FAIL reset_data: got %h want 00", bus.data_out); end
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    vecs++; if ({frame_err, parity_err, overrun} !== 3'b000) begin errs++; $display("FAIL reset_flags: got %b want 000", {frame_err, parity_err, overrun}); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_good_frame;
    bus.out_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    pop_exp;
    vecs++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL good_valid: got %b want 1", bus.out_valid); end
    vecs++; if (bus.data_out !== exp) begin errs++; $display("FAIL good_data: got %h want %h", bus.data_out, exp); end
    vecs++; if (frame_err !== 1'b0) begin errs++; $display("FAIL good_ferr: got %b want 0", frame_err); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL good_busy: got %b want 0", busy); end
    tick;
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL good_consume: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_stop_err;
    do_reset;
    bus.out_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs++; if (frame_err !== 1'b1) begin errs++; $display("FAIL stop_ferr: got %b want 1", frame_err); end
    vecs++; if (parity_err !== 1'b0) begin errs++; $display("FAIL stop_perr: got %b want 0", parity_err); end
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL stop_valid: got %b want 0", bus.out_valid); end
    vecs++; if (bus.data_out !== 8'h00) begin errs++; $display("FAIL stop_data: got %h want 00", bus.data_out); end
    tick;
    vecs++; if (frame_err !== 1'b0) begin errs++; $display("FAIL stop_ferr_pulse: got %b want 0", frame_err); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL stop_not_start: got %b want 0", busy); end
  endtask

`ifdef SERIAL_FRAME_PARITY_EN
  task automatic test_parity_err;
    do_reset;
    bus.out_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs++; if ({frame_err, parity_err} !== 2'b11) begin errs++; $display("FAIL par_flags: got %b want 11", {frame_err, parity_err}); end
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL par_valid: got %b want 0", bus.out_valid); end
    tick;
    vecs++; if ({frame_err, parity_err} !== 2'b00) begin errs++; $display("FAIL par_pulse: got %b want 00", {frame_err, parity_err}); end
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs++; if ({frame_err, parity_err} !== 2'b11) begin errs++; $display("FAIL par_and_stop: got %b want 11", {frame_err, parity_err}); end
    tick;
  endtask
`endif

  task automatic test_overrun;
    do_reset;
    bus.out_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL ovr_first: got %b want 0", overrun); end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    pop_exp;
    vecs++; if (bus.data_out !== exp) begin errs++; $display("FAIL ovr_data: got %h want %h", bus.data_out, exp); end
    vecs++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL ovr_valid: got %b want 1", bus.out_valid); end
    vecs++; if (overrun !== 1'b1) begin errs++; $display("FAIL ovr_set: got %b want 1", overrun); end
    bus.out_ready = 1'b1;
    tick;
    tick;
    tick;
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL ovr_consume: got %b want 0", bus.out_valid); end
    vecs++; if (overrun !== 1'b1) begin errs++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_mid_reset;
    bus.out_ready = 1'b1;
    serial_in = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      serial_in = i[0];
      tick;
    end
    reset = 1'b1;
    serial_in = 1'b1;
    tick;
    reset = 1'b0;
    serial_in = 1'b0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy: got %b want 0", busy); end
    vecs++; if ({bus.out_valid, frame_err, parity_err, overrun} !== 4'b0000) begin errs++; $display("FAIL mid_flags: got %b want 0000", {bus.out_valid, frame_err, parity_err, overrun}); end
    vecs++; if (bus.data_out !== 8'h00) begin errs++; $display("FAIL mid_data: got %h want 00", bus.data_out); end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    pop_exp;
    vecs++; if ({bus.out_valid, bus.data_out} !== {1'b1, exp}) begin errs++; $display("FAIL mid_next: got %b/%h want 1/%h", bus.out_valid, bus.data_out, exp); end
    tick;
  endtask

  task automatic test_consume_coincident;
    do_reset;
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    pop_exp;
    vecs++; if (bus.data_out !== exp) begin errs++; $display("FAIL coin_first: got %h want %h", bus.data_out, exp); end
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    pop_exp;
    vecs++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL coin_valid: got %b want 1", bus.out_valid); end
    vecs++; if (bus.data_out !== exp) begin errs++; $display("FAIL coin_data: got %h want %h", bus.data_out, exp); end
    vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL coin_ovr: got %b want 0", overrun); end
    tick;
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL coin_clear: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d, last_good;
    do_reset;
    bus.out_ready = 1'b1;
    last_good = 8'h00;
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      if (k == 3 || k == 6) begin
        send_frame(d, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs++; if (frame_err !== 1'b1) begin errs++; $display("FAIL b2b_ferr_%0d: got %b want 1", k, frame_err); end
        vecs++; if ({bus.out_valid, bus.data_out} !== {1'b0, last_good}) begin errs++; $display("FAIL b2b_hold_%0d: got %b/%h want 0/%h", k, bus.out_valid, bus.data_out, last_good); end
      end else begin
        exp_q.push_back(d);
        send_frame(d, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_exp;
        last_good = exp;
        vecs++; if ({bus.out_valid, bus.data_out} !== {1'b1, exp}) begin errs++; $display("FAIL b2b_word_%0d: got %b/%h want 1/%h", k, bus.out_valid, bus.data_out, exp); end
      end
    end
    tick;
    vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b1;
    serial_in = 1'b0;
    bus.out_ready = 1'b0;
    test_reset;
    test_good_frame;
    test_stop_err;
`ifdef SERIAL_FRAME_PARITY_EN
    test_parity_err;
`endif
    test_overrun;
    test_mid_reset;
    test_consume_coincident;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
